// File: rtl/tpu_pkg.sv
// tpu_pkg: shared instruction type, width and idle value
package tpu_pkg;
  localparam int INSTR_WIDTH = 80;
  typedef struct packed {
    logic [7:0]  opcode;
    logic [31:0] calc_length;
    logic [15:0] acc_addr;
    logic [23:0] buffer_addr;
  } instr_type;
  localparam instr_type INIT_INSTR = '0;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead FIFO (clk, active-low sync rst, push/din in, pop in, dout/full/empty/count out)
module sync_fifo #(
  parameter int WIDTH = 80,
  parameter int DEPTH = 32,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign full  = cnt_q == CW'(DEPTH);
  assign empty = cnt_q == '0;
  assign count = cnt_q;
  assign dout  = mem_q[rp_q];
  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    wp_d    = do_push ? wp_q + 1'b1 : wp_q;
    rp_d    = do_pop ? rp_q + 1'b1 : rp_q;
    cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk)
    if (rst && do_push) mem_q[wp_q] <= din;
endmodule

// File: rtl/instr_feeder.sv
// instr_feeder: assembles 80-bit instrs from lower/middle/upper word strobes into a FIFO feeding instr/instr_enable under busy/enable, with full/empty/count/overflow status
module instr_feeder
  import tpu_pkg::*;
#(
  parameter int FIFO_DEPTH = 32,
  localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     lower_word,
  input  logic            lower_write_en,
  input  logic [31:0]     middle_word,
  input  logic            middle_write_en,
  input  logic [15:0]     upper_word,
  input  logic            upper_write_en,
  output logic            full,
  output logic            empty,
  output logic [CW-1:0]   count,
  output logic            overflow,
  output instr_type       instr,
  output logic            instr_enable,
  input  logic            busy,
  input  logic            enable
);
  logic [31:0] lower_q, lower_d, middle_q, middle_d;
  logic overflow_q, overflow_d, pop;
  logic [INSTR_WIDTH-1:0] head;
  always_comb begin
    lower_d    = lower_write_en ? lower_word : lower_q;
    middle_d   = middle_write_en ? middle_word : middle_q;
    overflow_d = overflow_q | (upper_write_en & full);
    pop        = !empty && enable && !busy;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      lower_q    <= '0;
      middle_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      lower_q    <= lower_d;
      middle_q   <= middle_d;
      overflow_q <= overflow_d;
    end
  end
  sync_fifo #(.WIDTH(INSTR_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(upper_write_en), .pop(pop),
    .din({upper_word, middle_d, lower_d}), .dout(head),
    .full(full), .empty(empty), .count(count)
  );
  assign overflow     = overflow_q;
  assign instr_enable = !empty;
  assign instr        = empty ? INIT_INSTR : instr_type'(head);
endmodule

// File: tb/tb_instr_feeder.sv
// tb_instr_feeder: table vectors, corner sequences and randomized traffic checked against a queue model
module tb_instr_feeder;
  import tpu_pkg::*;
  localparam int D = 32;
  localparam int CW = $clog2(D + 1);
  logic clk = 0, rst = 0;
  logic [31:0] lower_word = 0, middle_word = 0;
  logic [15:0] upper_word = 0;
  logic lower_write_en = 0, middle_write_en = 0, upper_write_en = 0, busy = 0, enable = 0;
  logic full, empty, overflow, instr_enable;
  logic [CW-1:0] count;
  instr_type instr;
  always #5 clk = ~clk;
  instr_feeder #(.FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .lower_word(lower_word), .lower_write_en(lower_write_en),
    .middle_word(middle_word), .middle_write_en(middle_write_en), .upper_word(upper_word),
    .upper_write_en(upper_write_en), .full(full), .empty(empty), .count(count),
    .overflow(overflow), .instr(instr), .instr_enable(instr_enable), .busy(busy), .enable(enable)
  );
  int tests = 0, fails = 0;
  logic [79:0] q[$];
  logic [31:0] m_lo, m_mi;
  logic m_ovf;
  typedef struct {
    logic rst, lwe, mwe, uwe, busy, en;
    logic [31:0] lw, mw;
    logic [15:0] uw;
    int ecount;
    logic [79:0] einstr;
  } vec_t;
  vec_t tbl[7];
  task automatic chk(string n, logic [79:0] a, logic [79:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic drive(logic r, logic lwe, logic [31:0] lw, logic mwe, logic [31:0] mw,
                       logic uwe, logic [15:0] uw, logic b, logic en);
    rst = r; lower_write_en = lwe; lower_word = lw; middle_write_en = mwe; middle_word = mw;
    upper_write_en = uwe; upper_word = uw; busy = b; enable = en;
  endtask
  task automatic cyc();
    logic [79:0] w;
    logic pop, fl;
    w = {upper_word, middle_write_en ? middle_word : m_mi, lower_write_en ? lower_word : m_lo};
    @(posedge clk);
    if (!rst) begin
      q.delete(); m_lo = 0; m_mi = 0; m_ovf = 0;
    end else begin
      fl  = q.size() == D;
      pop = q.size() != 0 && enable && !busy;
      if (lower_write_en) m_lo = lower_word;
      if (middle_write_en) m_mi = middle_word;
      if (pop) void'(q.pop_front());
      if (upper_write_en) begin
        if (fl) m_ovf = 1;
        else q.push_back(w);
      end
    end
    #1;
    chk("count", 80'(count), 80'(q.size()));
    chk("empty", 80'(empty), 80'(q.size() == 0));
    chk("full", 80'(full), 80'(q.size() == D));
    chk("instr_enable", 80'(instr_enable), 80'(q.size() != 0));
    chk("overflow", 80'(overflow), 80'(m_ovf));
    chk("instr", instr, q.size() != 0 ? q[0] : 80'(INIT_INSTR));
  endtask
  initial begin
    tbl[0] = '{0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 16'h0, 0, 80'h0};
    tbl[1] = '{1, 1, 0, 0, 1, 1, 32'h3, 32'h0, 16'h0, 0, 80'h0};
    tbl[2] = '{1, 0, 1, 0, 1, 1, 32'h0, 32'h2, 16'h0, 0, 80'h0};
    tbl[3] = '{1, 0, 0, 1, 1, 1, 32'h0, 32'h0, 16'h8001, 1, 80'h8001_00000002_00000003};
    tbl[4] = '{1, 1, 1, 1, 1, 1, 32'haaaa5555, 32'h12345678, 16'hbeef, 2, 80'h8001_00000002_00000003};
    tbl[5] = '{1, 0, 0, 0, 0, 1, 32'h0, 32'h0, 16'h0, 1, 80'hbeef_12345678_aaaa5555};
    tbl[6] = '{1, 0, 0, 0, 0, 1, 32'h0, 32'h0, 16'h0, 0, 80'h0};
    for (int i = 0; i < 7; i++) begin
      drive(tbl[i].rst, tbl[i].lwe, tbl[i].lw, tbl[i].mwe, tbl[i].mw, tbl[i].uwe, tbl[i].uw,
            tbl[i].busy, tbl[i].en);
      cyc();
      chk($sformatf("vec%0d_count", i), 80'(count), 80'(tbl[i].ecount));
      chk($sformatf("vec%0d_instr", i), instr, tbl[i].einstr);
      if (i == 3) chk("vec3_opcode", 80'(instr.opcode), 80'h80);
    end
    // three commits held back by busy, then drained in order
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 32'h100 + i, 1, 32'h200 + i, 1, 16'h300 + 16'(i), 1, 1);
      cyc();
    end
    chk("busy_hold_count", 80'(count), 80'd3);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
      chk($sformatf("drain_head%0d", i), instr, {16'h300 + 16'(i), 32'h200 + i, 32'h100 + i});
      cyc();
    end
    chk("drain_empty", 80'(empty), 80'd1);
    // fill to full, then commit with a same-cycle pop: commit dropped
    for (int i = 0; i < D; i++) begin
      drive(1, 1, $urandom, 1, $urandom, 1, 16'($urandom), 1, 1);
      cyc();
    end
    chk("fill_full", 80'(full), 80'd1);
    drive(1, 1, 32'hdeadbeef, 1, 32'hdeadbeef, 1, 16'hdead, 0, 1);
    cyc();
    chk("ovf_set", 80'(overflow), 80'd1);
    chk("ovf_count", 80'(count), 80'd31);
    for (int i = 0; i < D; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
      if (!empty) chk("dropped_absent", 80'(instr == 80'hdead_deadbeef_deadbeef), 80'd0);
      cyc();
    end
    // refill to 5, then reset with a same-cycle commit and pop
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, $urandom, 0, 0, 1, 16'($urandom), 1, 1);
      cyc();
    end
    chk("pre_rst_count", 80'(count), 80'd5);
    drive(0, 1, 32'h1, 1, 32'h1, 1, 16'h1, 0, 1);
    cyc();
    chk("rst_count", 80'(count), 80'd0);
    chk("rst_empty", 80'(empty), 80'd1);
    chk("rst_ien", 80'(instr_enable), 80'd0);
    chk("rst_ovf", 80'(overflow), 80'd0);
    // randomized traffic, wrapping the pointers many times
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 99) != 0, $urandom_range(0, 1), $urandom, $urandom_range(0, 1),
            $urandom, $urandom_range(0, 2) != 0, 16'($urandom),
            $urandom_range(0, 3) == 0, $urandom_range(0, 5) != 0);
      cyc();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
